// File: rtl/seq_accumulator_64bit.sv
// ----------------------------------------------------------------------------
// ripple_carry_adder_64bit
//   Plain ripple-carry adder. The accumulator below instantiates it with
//   c_in tied low.
//   Ports:
//     a, b   in   WIDTH  operands
//     c_in   in   1      carry into bit 0
//     sum    out  WIDTH  a + b + c_in, modulo 2^WIDTH
//     c_out  out  1      carry out of the top bit
// ----------------------------------------------------------------------------
module ripple_carry_adder_64bit #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[WIDTH];

endmodule

// ----------------------------------------------------------------------------
// seq_accumulator_64bit
//   Sums a programmed number of 64-bit operands arriving on a valid/ready
//   stream, counts adder carry-outs, and presents the total on a valid/ready
//   output.
//
//   Handshake semantics (both streams): a transfer happens on a rising clock
//   edge where valid and ready are both high. in_ready and out_valid are
//   decoded from the registered state only, so neither depends
//   combinationally on in_valid or out_ready; in_data is ignored whenever
//   in_ready is low, and result/carry_count hold steady while out_valid is
//   high and out_ready is low.
//
//   Ports:
//     clk          in   1          rising-edge clock
//     rst_n        in   1          asynchronous active-low reset
//     start        in   1          begin a run (only honoured in IDLE)
//     num_ops      in   MAX_OPS_W  operand count, sampled with start
//     in_valid     in   1          operand valid
//     in_ready     out  1          high in ACCUM
//     in_data      in   64         operand
//     out_valid    out  1          high in DONE
//     out_ready    in   1          consumer accepts the result
//     result       out  64         accumulated sum mod 2^64
//     carry_count  out  MAX_OPS_W  adder carry-outs seen during the run
//     busy         out  1          high in ACCUM or DONE
//
//   The FSM state is held in the enum signal `state` so it can be observed
//   hierarchically.
// ----------------------------------------------------------------------------
module seq_accumulator_64bit #(
    parameter int MAX_OPS_W = 8,
    parameter int CARRY_SAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MAX_OPS_W-1:0] num_ops,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          result,
    output logic [MAX_OPS_W-1:0] carry_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [MAX_OPS_W-1:0] CNT_MAX = {MAX_OPS_W{1'b1}};

    state_t               state;
    logic [63:0]          acc;
    logic [MAX_OPS_W-1:0] carry_cnt;
    logic [MAX_OPS_W-1:0] remaining;

    logic [63:0]          add_sum;
    logic                 add_c_out;

    // The adder always sees the running total and the current stream word;
    // its output is only captured on an accepted beat.
    ripple_carry_adder_64bit #(
        .WIDTH (64)
    ) u_adder (
        .a     (acc),
        .b     (in_data),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 64'd0;
            carry_cnt <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= 64'd0;
                        carry_cnt <= '0;
                        remaining <= num_ops;
                        // A zero-length run goes straight to presenting 0.
                        state     <= (num_ops == '0) ? DONE : ACCUM;
                    end
                end

                ACCUM: begin
                    if (in_valid) begin
                        acc       <= add_sum;
                        remaining <= remaining - 1'b1;
                        if (add_c_out) begin
                            if (CARRY_SAT != 0 && carry_cnt == CNT_MAX) begin
                                carry_cnt <= carry_cnt;
                            end else begin
                                carry_cnt <= carry_cnt + 1'b1;
                            end
                        end
                        if (remaining == {{(MAX_OPS_W-1){1'b0}}, 1'b1}) begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here, so a start
                    // coinciding with the output handshake is dropped.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs are decodes of registered state or registers themselves.
    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign result      = acc;
    assign carry_count = carry_cnt;

endmodule

// File: tb/tb_seq_accumulator_64bit.sv
// ----------------------------------------------------------------------------
// Bench for seq_accumulator_64bit.
//   dut   : MAX_OPS_W=8, CARRY_SAT=1, checked every cycle against a
//           reference model of the run (operand count left, 65-bit sum).
//   dut_s : MAX_OPS_W=2, CARRY_SAT=1, small directed run.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_seq_accumulator_64bit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic        start     = 1'b0;
    logic [7:0]  num_ops   = 8'd0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] in_data   = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic [7:0]  carry_count;
    logic        busy;

    seq_accumulator_64bit #(
        .MAX_OPS_W (8),
        .CARRY_SAT (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_ops     (num_ops),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry_count (carry_count),
        .busy        (busy)
    );

    // ---------------- narrow-count DUT ----------------
    logic        start_s     = 1'b0;
    logic [1:0]  num_ops_s   = 2'd0;
    logic        in_valid_s  = 1'b0;
    logic        in_ready_s;
    logic [63:0] in_data_s   = 64'd0;
    logic        out_valid_s;
    logic        out_ready_s = 1'b0;
    logic [63:0] result_s;
    logic [1:0]  carry_count_s;
    logic        busy_s;

    seq_accumulator_64bit #(
        .MAX_OPS_W (2),
        .CARRY_SAT (1)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_s),
        .num_ops     (num_ops_s),
        .in_valid    (in_valid_s),
        .in_ready    (in_ready_s),
        .in_data     (in_data_s),
        .out_valid   (out_valid_s),
        .out_ready   (out_ready_s),
        .result      (result_s),
        .carry_count (carry_count_s),
        .busy        (busy_s)
    );

    // ---------------- counters / check ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 = waiting for start, 1 = collecting operands,
    //          2 = presenting the total.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [63:0] m_sum   = 64'd0;
    int          m_cc    = 0;
    logic [64:0] wide;
    logic [63:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_sum   = 64'd0;
            m_cc    = 0;
            exp_q.delete();
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    m_sum  = 64'd0;
                    m_cc   = 0;
                    m_left = int'(num_ops);
                    if (m_left == 0) begin
                        m_phase = 2;
                        exp_q.push_back(m_sum);
                    end else begin
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    wide  = {1'b0, m_sum} + {1'b0, in_data};
                    m_sum = wide[63:0];
                    if (wide[64] && m_cc < 255) m_cc = m_cc + 1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 2;
                        exp_q.push_back(m_sum);
                    end
                end
            end else begin
                if (out_ready) m_phase = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("in_ready",  {63'd0, in_ready},  {63'd0, m_phase == 1});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
        check("busy",      {63'd0, busy},      {63'd0, m_phase != 0});
        if (m_phase != 1) begin
            check("result",      result,              m_sum);
            check("carry_count", {56'd0, carry_count}, 64'(m_cc));
        end
        if (m_phase == 2 && out_ready && rst_n) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                check("scoreboard_result", result, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: rand_operand = v;
            1: rand_operand = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
            2: rand_operand = 64'($urandom_range(0, 100));
            default: rand_operand = {1'b1, v[62:0]};
        endcase
    endfunction

    task automatic do_start(input int n);
        start   = 1'b1;
        num_ops = 8'(n);
        tick();
        start   = 1'b0;
    endtask

    // Present one operand until it is accepted, then idle for `gap` cycles.
    // poke_start drives a stray start alongside the operand.
    task automatic send(input logic [63:0] x, input int gap, input bit poke_start);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        if (poke_start) begin
            start   = 1'b1;
            num_ops = 8'($urandom_range(1, 9));
        end
        for (int i = 0; i < 40 && !taken; i++) begin
            taken = in_ready;
            tick();
            start = 1'b0;
        end
        if (!taken) check("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        repeat (gap) tick();
    endtask

    // Wait for the result, stall for `hold` cycles, then accept it.
    task automatic collect(input int hold, input bit start_too);
        for (int i = 0; i < 60 && !out_valid; i++) tick();
        if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
        out_ready = 1'b0;
        repeat (hold) tick();
        out_ready = 1'b1;
        if (start_too) begin
            start   = 1'b1;
            num_ops = 8'($urandom_range(1, 4));
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Two operands, back to back.
        do_start(2);
        send(64'd12345678912345, 0, 1'b0);
        send(64'd98765432198765, 0, 1'b0);
        check("t1_latency", {63'd0, out_valid}, 64'd1);
        check("t1_result", result, 64'd111111111111110);
        check("t1_carry", {56'd0, carry_count}, 64'd0);
        collect(0, 1'b0);

        // Exact wrap to zero produces one carry.
        do_start(2);
        send(64'd18446744073709551610, 0, 1'b0);
        send(64'd6, 0, 1'b0);
        check("t2_result", result, 64'd0);
        check("t2_carry", {56'd0, carry_count}, 64'd1);
        collect(1, 1'b0);

        // One short of wrapping: no carry.
        do_start(2);
        send(64'd18446744073709551610, 0, 1'b0);
        send(64'd5, 0, 1'b0);
        check("t3_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_carry", {56'd0, carry_count}, 64'd0);
        collect(0, 1'b1);
        tick();

        // Gapped operands, then a five-cycle stall on the output.
        do_start(3);
        send(64'd1, 2, 1'b0);
        send(64'd2, 2, 1'b0);
        send(64'd3, 2, 1'b0);
        check("t4_result", result, 64'd6);
        collect(5, 1'b0);
        check("t4_idle_after", {63'd0, busy}, 64'd0);

        // Zero-length run.
        do_start(0);
        check("t5_done", {63'd0, out_valid}, 64'd1);
        check("t5_result", result, 64'd0);
        collect(2, 1'b0);

        // Reset in the middle of a run.
        do_start(3);
        send(64'd100, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_result", result, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_start(3);
        send(64'd4, 0, 1'b0);
        send(64'd5, 1, 1'b1);
        send(64'd6, 0, 1'b0);
        check("t6_result", result, 64'd15);
        collect(0, 1'b0);

        // Random runs.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(0, 6);
            do_start(n);
            for (int k = 0; k < n; k++) begin
                send(rand_operand(), $urandom_range(0, 2), $urandom_range(0, 4) == 0);
            end
            collect($urandom_range(0, 3), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Narrow-count instance: three all-ones operands, stray start mid-run.
        start_s   = 1'b1;
        num_ops_s = 2'd3;
        tick();
        start_s    = 1'b0;
        in_valid_s = 1'b1;
        in_data_s  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            check("s_in_ready", {63'd0, in_ready_s}, 64'd1);
            if (k == 1) begin
                start_s   = 1'b1;
                num_ops_s = 2'd1;
            end
            tick();
            start_s = 1'b0;
        end
        in_valid_s = 1'b0;
        check("s_out_valid", {63'd0, out_valid_s}, 64'd1);
        check("s_result", result_s, 64'hFFFF_FFFF_FFFF_FFFD);
        check("s_carry", {62'd0, carry_count_s}, 64'd2);
        out_ready_s = 1'b1;
        tick();
        out_ready_s = 1'b0;
        check("s_idle", {63'd0, busy_s}, 64'd0);
        check("s_result_hold", result_s, 64'hFFFF_FFFF_FFFF_FFFD);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
